mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Data-memory responder for the MIPS pipeline MEM stage.
- Consumes the memory controls the decode stage produces (mem_read, mem_we, mem_byte, mem_signextend, LL/SC), drives a valid/grant data-memory bus, and returns load or SC results.
- Owns the LL/SC reservation register.
- Stalls the pipeline while a bus transaction is outstanding.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; fixed at 32.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- req_valid  in  1  memory op present in MEM stage.
- mem_read  in  1  load (LW/LB/LBU/LL).
- mem_we  in  1  store (SW/SB/SC).
- mem_byte  in  1  byte-sized access.
- mem_signextend  in  1  sign-extend byte load.
- mem_ll  in  1  load-linked.
- mem_sc  in  1  store-conditional.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rt).
- mem_stall  out  1  hold pipeline.
- rdata  out  32  load data, or SC result 0/1.
- rdata_valid  out  1  result valid, one-cycle pulse.
- misaligned  out  1  one-cycle pulse on an unaligned word access.
- link_valid  out  1  reservation held.
- dmem_req  out  1  bus request.
- dmem_we  out  1  bus write.
- dmem_be  out  4  byte enables.
- dmem_addr  out  32  word-aligned address.
- dmem_wdata  out  32  bus write data.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  read data.
- snoop_we  in  1  external write observed.
- snoop_addr  in  32  external write address.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; link_valid 0.
- Reset mid-transaction: abort immediately and drop dmem_req. The bus tolerates abandoned requests.
- All dmem_* outputs, rdata, rdata_valid and misaligned are registered.
- mem_stall = req_valid & (mem_read|mem_we) & (state != DONE). It is combinational and low in DONE.
- Upstream holds all inputs stable while mem_stall=1.
- IDLE:
  - No op, or req_valid=0: remain in IDLE.
  - Misaligned: word access with addr[1:0]!=0 -> go to DONE with misaligned=1 and rdata=0. No bus access, no reservation change.
  - Failing SC: mem_sc with (!link_valid | link_addr != addr[31:2]) -> go to DONE with rdata=0. No bus access. Clear link_valid.
  - Otherwise: capture addr[1:0], mem_byte and mem_signextend; load dmem_* and go to REQ.
- REQ:
  - dmem_req=1; address, we, be and wdata held stable until dmem_gnt.
  - On gnt: a write goes to DONE; a read goes to WAIT.
- WAIT: on dmem_rvalid, capture and format data into rdata and go to DONE.
- DONE: rdata_valid=1 for one cycle, then IDLE.
- Minimum latency (gnt in first REQ cycle):
  - Store: 2 stall cycles, result in cycle 2.
  - Load with rvalid in the cycle after gnt: 3 stall cycles.
- Byte store: dmem_be = 4'b0001 << addr[1:0] (little-endian); dmem_wdata = {4{wdata[7:0]}}.
- Word store: be=4'b1111.
- Byte load: take lane dmem_rdata[8*addr[1:0] +: 8]; sign- or zero-extend per the captured mem_signextend.
- dmem_addr = {addr[31:2], 2'b00}.
- Reservation updates:
  - LL: reaching DONE sets link_valid=1 and link_addr=addr[31:2].
  - Successful SC: performs a word write and returns rdata=1.
  - Any SC, pass or fail: clears link_valid in DONE.
  - SW/SB by this unit to link_addr: clears link_valid at gnt.
  - snoop_we with snoop_addr[31:2]==link_addr: clears link_valid that cycle.
- Simultaneous events:
  - Snoop clear and LL set to the same word in the same cycle: the clear wins.
  - Snoop clear while an SC is in REQ: the SC still completes, since the reservation was checked in IDLE.

Decomposition:
- Shared package mem_access_pkg:
  - state enum IDLE/REQ/WAIT/DONE;
  - byte-enable constants BE_WORD and BE_BYTE0;
  - lane-select helper.
- One sub-module, ll_sc_reservation. It holds link_valid and link_addr, with set, sc_clear, store_clear and snoop_clear inputs and clear-wins priority.

Test Plan:
- LW addr=0x100, gnt in the first REQ cycle, rvalid one cycle later with 0xDEADBEEF -> mem_stall high 3 cycles, rdata=0xDEADBEEF, rdata_valid single pulse.
- LB addr=0x103, rdata word 0x80FF7F01 -> rdata=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SB addr=0x102, wdata=0x000000AB -> dmem_be=4'b0100, dmem_wdata=0xABABABAB, dmem_addr=0x100. With gnt delayed 4 cycles, REQ outputs stay stable throughout.
- LL 0x200 then SC 0x200 wdata=7 -> SC writes word 7 and returns rdata=1; link_valid=0 afterwards. A second SC to 0x200 -> rdata=0 with no dmem_req.
- LL 0x200, then snoop_we with snoop_addr=0x203, then SC 0x200 -> SC fails with rdata=0. Snoop coincident with LL DONE -> link_valid stays 0.
- LW addr=0x102 -> misaligned pulse, no dmem_req. Separately, assert rst_n=0 during WAIT -> dmem_req, mem_stall and link_valid go to 0 immediately and state returns to IDLE.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the MEM-stage data-memory responder.
package mem_access_pkg;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   localparam logic [3:0] BE_WORD  = 4'b1111;
   localparam logic [3:0] BE_BYTE0 = 4'b0001;

   // Little-endian byte lane lo of a 32-bit word.
   function automatic logic [7:0] lane_sel(input logic [31:0] word, input logic [1:0] lo);
      return 8'(word >> {lo, 3'b000});
   endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// Valid/grant data-memory bus between the MEM stage and the memory system.
interface mem_access_unit_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
   logic              dmem_req;
   logic              dmem_we;
   logic [3:0]        dmem_be;
   logic [ADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic              dmem_gnt;
   logic              dmem_rvalid;
   logic [DATA_W-1:0] dmem_rdata;

   modport master (output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
                   input  dmem_gnt, dmem_rvalid, dmem_rdata);
   modport slave  (input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
                   output dmem_gnt, dmem_rvalid, dmem_rdata);
endinterface

// File: rtl/mem_access_unit_ll_sc_reservation.sv
// LL/SC reservation register; any clear source beats a simultaneous set.
module ll_sc_reservation #(parameter int WA_W = 30) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            set,
   input  logic [WA_W-1:0] set_addr,
   input  logic            sc_clear,
   input  logic            store_clear,
   input  logic            snoop_clear,
   output logic            link_valid,
   output logic [WA_W-1:0] link_addr
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         link_valid <= 1'b0;
         link_addr  <= '0;
      end else if (sc_clear | store_clear | snoop_clear) begin
         link_valid <= 1'b0;
      end else if (set) begin
         link_valid <= 1'b1;
         link_addr  <= set_addr;
      end
   end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory responder: drives the dmem bus, formats loads, resolves SC.
module mem_access_unit import mem_access_pkg::*; #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              mem_read,
   input  logic              mem_we,
   input  logic              mem_byte,
   input  logic              mem_signextend,
   input  logic              mem_ll,
   input  logic              mem_sc,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              mem_stall,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              misaligned,
   output logic              link_valid,
   mem_access_unit_if.master dmem,
   input  logic              snoop_we,
   input  logic [ADDR_W-1:0] snoop_addr
);
   localparam int WA_W = ADDR_W - 2;

   state_t          state;
   logic [1:0]      lo_q;
   logic            byte_q, sext_q, ll_q, sc_q;
   logic [WA_W-1:0] link_addr;
   logic            op, word_mis, sc_fail;
   logic            res_set, res_sc_clr, res_st_clr, res_snp_clr;
   logic [7:0]      lane;
   logic            unused_snoop_lo;

   assign op        = req_valid & (mem_read | mem_we);
   // Reset also releases the pipeline so an aborted access does not hold it.
   assign mem_stall = rst_n & op & (state != DONE);
   assign word_mis  = ~mem_byte & (addr[1:0] != 2'b00);
   assign sc_fail   = mem_sc & (~link_valid | (link_addr != addr[ADDR_W-1:2]));
   assign lane      = lane_sel(dmem.dmem_rdata, lo_q);

   assign res_set     = (state == DONE) & ll_q & ~misaligned;
   assign res_sc_clr  = (state == DONE) & sc_q & ~misaligned;
   assign res_st_clr  = (state == REQ) & dmem.dmem_gnt & dmem.dmem_we
                      & (dmem.dmem_addr[ADDR_W-1:2] == link_addr);
   // While an LL is being linked, compare the snoop against the word being linked.
   assign res_snp_clr = snoop_we & (snoop_addr[ADDR_W-1:2] ==
                        (res_set ? dmem.dmem_addr[ADDR_W-1:2] : link_addr));
   assign unused_snoop_lo = &{1'b0, snoop_addr[1:0]};

   ll_sc_reservation #(.WA_W(WA_W)) u_resv (
      .clk        (clk),
      .rst_n      (rst_n),
      .set        (res_set),
      .set_addr   (dmem.dmem_addr[ADDR_W-1:2]),
      .sc_clear   (res_sc_clr),
      .store_clear(res_st_clr),
      .snoop_clear(res_snp_clr),
      .link_valid (link_valid),
      .link_addr  (link_addr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         lo_q            <= '0;
         byte_q          <= 1'b0;
         sext_q          <= 1'b0;
         ll_q            <= 1'b0;
         sc_q            <= 1'b0;
         rdata           <= '0;
         rdata_valid     <= 1'b0;
         misaligned      <= 1'b0;
         dmem.dmem_req   <= 1'b0;
         dmem.dmem_we    <= 1'b0;
         dmem.dmem_be    <= '0;
         dmem.dmem_addr  <= '0;
         dmem.dmem_wdata <= '0;
      end else begin
         rdata_valid <= 1'b0;
         misaligned  <= 1'b0;
         case (state)
            IDLE: if (op) begin
               lo_q   <= addr[1:0];
               byte_q <= mem_byte;
               sext_q <= mem_signextend;
               ll_q   <= mem_ll;
               sc_q   <= mem_sc;
               if (word_mis || sc_fail) begin
                  state       <= DONE;
                  misaligned  <= word_mis;
                  rdata       <= '0;
                  rdata_valid <= 1'b1;
               end else begin
                  state           <= REQ;
                  dmem.dmem_req   <= 1'b1;
                  dmem.dmem_we    <= mem_we;
                  dmem.dmem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                  dmem.dmem_be    <= mem_byte ? (BE_BYTE0 << addr[1:0]) : BE_WORD;
                  dmem.dmem_wdata <= mem_byte ? {4{wdata[7:0]}} : wdata;
               end
            end
            REQ: if (dmem.dmem_gnt) begin
               dmem.dmem_req <= 1'b0;
               if (dmem.dmem_we) begin
                  state       <= DONE;
                  rdata       <= {{(DATA_W-1){1'b0}}, sc_q};
                  rdata_valid <= 1'b1;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: if (dmem.dmem_rvalid) begin
               state       <= DONE;
               rdata_valid <= 1'b1;
               rdata       <= byte_q ? {{(DATA_W-8){sext_q & lane[7]}}, lane} : dmem.dmem_rdata;
            end
            DONE: state <= IDLE;
         endcase
      end
   end
endmodule
